memory_cycle: RTL
=================

MEMORY_CYCLE -- requirements
Module: memory_cycle

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, the number of BUSY cycles without dmem_ready before an access is aborted.
REQ-002 SHALL have ports: clk in 1, rising-edge clock; rst in 1, reset, asynchronous, active-low.
REQ-003 SHALL have M-stage inputs: RegWriteM 1; MemWriteM 1; ResultSrcM 2; RD_M 5; funct3M 3, load/store width; ALU_ResultM 32, address or result; WriteDataM 32, store data; PCPlus4M 32.
REQ-004 SHALL have data-memory port: dmem_req out 1; dmem_we out 1; dmem_addr out 32, word-aligned; dmem_be out 4; dmem_wdata out 32; dmem_ready in 1; dmem_rdata in 32.
REQ-005 SHALL have W-stage outputs: RegWriteW 1; RD_W 5; ResultSrcW 2; ALU_ResultW 32; ReadDataW 32; PCPlus4W 32; ResultW 32, writeback value.
REQ-006 SHALL have status outputs: StallM out 1, which holds the F/D/E/M stages; MisalignW out 1, a one-cycle flag; TimeoutErr out 1, sticky.

Function
REQ-007 Memory op = MemWriteM=1 (store), or ResultSrcM=01 with MemWriteM=0 (load); all else pass through.
REQ-008 Pass-through op SHALL reach the W register on the next clk edge (latency 1) with StallM=0.
REQ-009 FSM states SHALL be IDLE and BUSY; reset state SHALL be IDLE.
REQ-010 In IDLE with an aligned memory op: dmem_req=1 combinationally; if dmem_ready=1 in the same cycle, the op SHALL complete with no stall and the FSM SHALL stay in IDLE.
REQ-011 In IDLE with dmem_ready=0: StallM=1, and the FSM SHALL go to BUSY on the next edge.
REQ-012 In BUSY: dmem_req, addr, we, be and wdata held stable; StallM=1 until the dmem_ready cycle; on dmem_ready the FSM SHALL complete the op and go to IDLE.
REQ-013 While StallM=1 the W register SHALL load a bubble: RegWriteW=0, MisalignW=0.
REQ-014 A BUSY cycle counter SHALL reset on entry to BUSY; when it reaches TIMEOUT_CYCLES without dmem_ready, the FSM SHALL:
- set TimeoutErr;
- complete the op with ReadDataW=0 and RegWriteW=0;
- go to IDLE.
REQ-015 dmem_addr SHALL equal {ALU_ResultM[31:2],2'b00}, and dmem_we SHALL equal MemWriteM.
REQ-016 Store byte enables:
- SB: dmem_be=0001<<addr[1:0], wdata = byte replicated x4.
- SH: dmem_be = 0011 if addr[1]=0, else 1100, wdata = half replicated x2.
- SW: dmem_be=1111.
REQ-017 Loads SHALL set dmem_be=1111 and extract by addr[1:0]:
- LB (000) / LH (001): sign-extend.
- LW (010): full word.
- LBU (100) / LHU (101): zero-extend.
REQ-018 Misaligned access (H with addr[0]=1, W with addr[1:0]!=0):
- no dmem_req, no stall;
- W register gets RegWriteW=0 and MisalignW=1 for one cycle.
REQ-019 ResultW SHALL be selected by ResultSrcW: 00 ALU_ResultW; 01 ReadDataW; 10 PCPlus4W; 11 zero.
REQ-020 Unsupported load/store funct3 (011, 110, 111) SHALL be treated as misaligned.

Reset
REQ-021 While rst=0:
- FSM in IDLE and counter 0;
- dmem_req=0, StallM=0;
- all W registers 0, MisalignW=0 and TimeoutErr=0.
REQ-022 rst asserted mid-BUSY SHALL drop dmem_req immediately (asynchronously), and a late dmem_ready SHALL then be ignored.

Structure
REQ-023 Package rv32_mem_pkg SHALL hold:
- funct3 load/store encodings;
- ResultSrc encodings;
- the FSM state type;
- the TIMEOUT_CYCLES default.
REQ-024 Sub-module load_extender SHALL be used: combinational, inputs rdata/addr[1:0]/funct3, output the extended 32-bit ReadData.

Verification
REQ-025 ALU op, RegWriteM=1, RD_M=5, ALU_ResultM=0x1234 -> next cycle RegWriteW=1, RD_W=5, ResultW=0x1234, StallM never 1.
REQ-026 LB at addr 0x103, dmem_rdata=0x80000000, dmem_ready after 3 cycles:
- StallM=1 for 3 cycles;
- then ReadDataW=0xFFFFFF80;
- bubble cycles have RegWriteW=0.
REQ-027 SH at addr 0x202, WriteDataM=0xABCD, dmem_ready immediate -> dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_we=1, no stall.
REQ-028 LW at addr 0x101 -> dmem_req=0, MisalignW=1 for one cycle, RegWriteW=0.
REQ-029 Load with dmem_ready held 0:
- after 16 BUSY cycles, TimeoutErr=1 and StallM=0;
- TimeoutErr stays 1 until rst.
REQ-030 rst=0 during BUSY -> dmem_req=0 and StallM=0 the same cycle; after release, FSM in IDLE.

Source files
------------

// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the RV32 memory (M) stage and its writeback register.
//   - funct3 encodings for loads and stores
//   - ResultSrc writeback-mux encodings
//   - memory-cycle FSM state type and state constants
//   - default abort timeout for a stalled data-memory access
//   - the request bundle presented on the data-memory port
//   - helpers that classify funct3 / address combinations
package rv32_mem_pkg;

    localparam int TIMEOUT_CYCLES_DEFAULT = 16;

    // Load encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Writeback source select
    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_MEM  = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;
    localparam logic [1:0] RES_ZERO = 2'b11;

    // Memory-cycle FSM
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_BUSY = 1'b1;

    // Everything the data-memory port needs, plus what the load path needs
    // to pick the right bytes once the read data arrives.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [1:0]  lo;
        logic [2:0]  funct3;
    } mem_req_t;

    // Encodings that have no load/store meaning in RV32I.
    function automatic logic f3_unsupported(input logic [2:0] f3);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    // Halfword needs addr[0]=0, word needs addr[1:0]=0; bytes are always fine.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = lo[0];
            2'b10:   mis = (lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_extender.sv
// Load data alignment and extension.
//   rdata     in  32  raw word returned by data memory
//   addr      in  2   byte offset of the load within the word
//   funct3    in  3   load type (LB/LH/LW/LBU/LHU)
//   read_data out 32  value to be written back
// Purely combinational; unsupported funct3 yields zero.
module load_extender
    import rv32_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] read_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte/halfword and extend it per load type
    always_comb begin
        byte_s    = 8'h00;
        half_s    = 16'h0000;
        read_data = 32'h0000_0000;
        case (addr)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (funct3)
            F3_LB:   read_data = {{24{byte_s[7]}}, byte_s};
            F3_LH:   read_data = {{16{half_s[15]}}, half_s};
            F3_LW:   read_data = rdata;
            F3_LBU:  read_data = {24'h00_0000, byte_s};
            F3_LHU:  read_data = {16'h0000, half_s};
            default: read_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/memory_cycle.sv
// RV32 memory stage with data-memory handshake and M/W pipeline register.
//   clk, rst (async, active-low)
//   M-stage inputs : RegWriteM, MemWriteM, ResultSrcM, RD_M, funct3M,
//                    ALU_ResultM (address/result), WriteDataM, PCPlus4M
//   dmem port      : dmem_req/we/addr/be/wdata out, dmem_ready/rdata in
//   W-stage outputs: RegWriteW, RD_W, ResultSrcW, ALU_ResultW, ReadDataW,
//                    PCPlus4W, ResultW (writeback value)
//   status         : StallM (freezes F/D/E/M), MisalignW (one cycle),
//                    TimeoutErr (sticky until reset)
// An aligned load/store that is not acknowledged in its first cycle parks the
// FSM in BUSY, holds the request and stalls the pipeline; the W register
// receives bubbles until the access completes or times out.
module memory_cycle
    import rv32_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [4:0]  RD_M,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALU_ResultM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] PCPlus4M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        RegWriteW,
    output logic [4:0]  RD_W,
    output logic [1:0]  ResultSrcW,
    output logic [31:0] ALU_ResultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] PCPlus4W,
    output logic [31:0] ResultW,
    output logic        StallM,
    output logic        MisalignW,
    output logic        TimeoutErr
);

    // Counter only has to hold 0..TIMEOUT_CYCLES-1: the last value aborts.
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic        is_store_s, is_load_s, mem_op_s, misalign_m_s, access_ok_s;
    mem_req_t    new_req_s, cur_req_s, req_d, req_q;
    state_t      state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic        stall_s, req_s, complete_s, timeout_s, misalign_s;
    logic [31:0] ext_data_s;

    logic        regwrite_w_d, regwrite_w_q;
    logic [4:0]  rd_w_d, rd_w_q;
    logic [1:0]  result_src_w_d, result_src_w_q;
    logic [31:0] alu_result_w_d, alu_result_w_q;
    logic [31:0] read_data_w_d, read_data_w_q;
    logic [31:0] pc_plus4_w_d, pc_plus4_w_q;
    logic [31:0] result_w_d, result_w_q;
    logic        misalign_w_d, misalign_w_q;
    logic        timeout_err_d, timeout_err_q;

    // Classify the M-stage op: store, load, or plain pass-through
    always_comb begin
        is_store_s   = MemWriteM;
        is_load_s    = (ResultSrcM == RES_MEM) && !MemWriteM;
        mem_op_s     = is_store_s || is_load_s;
        misalign_m_s = mem_op_s &&
                       (f3_unsupported(funct3M) || is_misaligned(funct3M, ALU_ResultM[1:0]));
        access_ok_s  = mem_op_s && !misalign_m_s;
    end

    // Build the request for the current M-stage op (lanes for stores)
    always_comb begin
        new_req_s        = '0;
        new_req_s.we     = MemWriteM;
        new_req_s.addr   = {ALU_ResultM[31:2], 2'b00};
        new_req_s.lo     = ALU_ResultM[1:0];
        new_req_s.funct3 = funct3M;
        new_req_s.be     = 4'b1111;
        new_req_s.wdata  = 32'h0000_0000;
        if (is_store_s) begin
            case (funct3M[1:0])
                2'b00: begin
                    new_req_s.be    = 4'b0001 << ALU_ResultM[1:0];
                    new_req_s.wdata = {4{WriteDataM[7:0]}};
                end
                2'b01: begin
                    new_req_s.be    = ALU_ResultM[1] ? 4'b1100 : 4'b0011;
                    new_req_s.wdata = {2{WriteDataM[15:0]}};
                end
                default: begin
                    new_req_s.be    = 4'b1111;
                    new_req_s.wdata = WriteDataM;
                end
            endcase
        end else begin
            new_req_s.be    = 4'b1111;
            new_req_s.wdata = 32'h0000_0000;
        end
    end

    // While BUSY the captured request drives the port so it cannot wander
    always_comb begin
        if (state_q == ST_BUSY) begin
            cur_req_s = req_q;
        end else begin
            cur_req_s = new_req_s;
        end
    end

    load_extender u_load_extender (
        .rdata     (dmem_rdata),
        .addr      (cur_req_s.lo),
        .funct3    (cur_req_s.funct3),
        .read_data (ext_data_s)
    );

    // FSM next state, BUSY cycle counter and handshake decisions
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        stall_s    = 1'b0;
        req_s      = 1'b0;
        complete_s = 1'b0;
        timeout_s  = 1'b0;
        misalign_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access_ok_s) begin
                    req_s = 1'b1;
                    if (dmem_ready) begin
                        complete_s = 1'b1;
                    end else begin
                        stall_s = 1'b1;
                        state_d = ST_BUSY;
                        cnt_d   = '0;
                        req_d   = new_req_s;
                    end
                end else begin
                    misalign_s = misalign_m_s;
                end
            end
            ST_BUSY: begin
                req_s = 1'b1;
                if (dmem_ready) begin
                    complete_s = 1'b1;
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // Abort: release the pipeline with a non-writing result
                    timeout_s = 1'b1;
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                end else begin
                    stall_s = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Next W-register contents: bubble while stalled, else the M-stage op
    always_comb begin
        regwrite_w_d   = 1'b0;
        rd_w_d         = 5'd0;
        result_src_w_d = 2'b00;
        alu_result_w_d = 32'h0000_0000;
        read_data_w_d  = 32'h0000_0000;
        pc_plus4_w_d   = 32'h0000_0000;
        misalign_w_d   = 1'b0;
        result_w_d     = 32'h0000_0000;
        if (stall_s) begin
            regwrite_w_d = 1'b0;
            misalign_w_d = 1'b0;
        end else begin
            regwrite_w_d   = RegWriteM && !misalign_s && !timeout_s;
            rd_w_d         = RD_M;
            result_src_w_d = ResultSrcM;
            alu_result_w_d = ALU_ResultM;
            pc_plus4_w_d   = PCPlus4M;
            misalign_w_d   = misalign_s;
            if (complete_s && !cur_req_s.we) begin
                read_data_w_d = ext_data_s;
            end else begin
                read_data_w_d = 32'h0000_0000;
            end
        end
        case (result_src_w_d)
            RES_ALU:  result_w_d = alu_result_w_d;
            RES_MEM:  result_w_d = read_data_w_d;
            RES_PC4:  result_w_d = pc_plus4_w_d;
            RES_ZERO: result_w_d = 32'h0000_0000;
            default:  result_w_d = 32'h0000_0000;
        endcase
        timeout_err_d = timeout_err_q || timeout_s;
    end

    // State, counter, held request and W register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            req_q          <= '0;
            regwrite_w_q   <= 1'b0;
            rd_w_q         <= 5'd0;
            result_src_w_q <= 2'b00;
            alu_result_w_q <= 32'h0000_0000;
            read_data_w_q  <= 32'h0000_0000;
            pc_plus4_w_q   <= 32'h0000_0000;
            result_w_q     <= 32'h0000_0000;
            misalign_w_q   <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            req_q          <= req_d;
            regwrite_w_q   <= regwrite_w_d;
            rd_w_q         <= rd_w_d;
            result_src_w_q <= result_src_w_d;
            alu_result_w_q <= alu_result_w_d;
            read_data_w_q  <= read_data_w_d;
            pc_plus4_w_q   <= pc_plus4_w_d;
            result_w_q     <= result_w_d;
            misalign_w_q   <= misalign_w_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    // Reset gates the handshake combinationally so a pending BUSY request
    // disappears the moment rst falls, not at the next clock.
    assign dmem_req    = rst && req_s;
    assign StallM      = rst && stall_s;
    assign dmem_we     = cur_req_s.we;
    assign dmem_addr   = cur_req_s.addr;
    assign dmem_be     = cur_req_s.be;
    assign dmem_wdata  = cur_req_s.wdata;

    assign RegWriteW   = regwrite_w_q;
    assign RD_W        = rd_w_q;
    assign ResultSrcW  = result_src_w_q;
    assign ALU_ResultW = alu_result_w_q;
    assign ReadDataW   = read_data_w_q;
    assign PCPlus4W    = pc_plus4_w_q;
    assign ResultW     = result_w_q;
    assign MisalignW   = misalign_w_q;
    assign TimeoutErr  = timeout_err_q;

endmodule
